// File: rtl/hamming_pkg.sv
// Shared constants, FSM state type and the Hamming(15,11) data-position table
// used by the 2D Hamming encode/decode path.
package hamming_pkg;

  localparam int HAM_DATA_W   = 11;
  localparam int HAM_CODE_W   = 15;
  localparam int HAM74_DATA_W = 4;
  localparam int HAM74_CODE_W = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // 1-based codeword position of data bit d[i]; powers of two are parity slots.
  localparam int HAM_DATA_POS [HAM_DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

endpackage

// File: rtl/hamming1511_encoder.sv
// Combinational Hamming(15,11) encoder: codeword bit k-1 holds position k,
// even parity at positions 1, 2, 4 and 8.
module hamming1511_encoder
  import hamming_pkg::*;
(
  input  logic [HAM_DATA_W-1:0] data,
  output logic [HAM_CODE_W-1:0] code
);

  logic par;

  always_comb begin
    code = '0;
    par  = 1'b0;
    for (int i = 0; i < HAM_DATA_W; i++) begin
      code[HAM_DATA_POS[i]-1] = data[i];
    end
    // Parity slots are still zero here, so they drop out of their own XOR.
    for (int p = 0; p < 4; p++) begin
      par = 1'b0;
      for (int k = 1; k <= HAM_CODE_W; k++) begin
        if (((k >> p) & 1) == 1) par = par ^ code[k-1];
      end
      code[(1 << p) - 1] = par;
    end
  end

endmodule

// File: rtl/hamming_2d_encoder.sv
// Sequential 2D Hamming block encoder: one Hamming(15,11) column per cycle,
// frame presented on valid/ready. Optional HAMMING_ERR_INJECT_EN adds a single-bit flip.
module hamming_2d_encoder
  import hamming_pkg::*;
#(
  parameter int NUM_COLS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [HAM_DATA_W*NUM_COLS-1:0] data_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [HAM_CODE_W*NUM_COLS-1:0] encoded_out,
`ifdef HAMMING_ERR_INJECT_EN
  input  logic                         inj_en,
  input  logic [$clog2(HAM_CODE_W*NUM_COLS)-1:0] inj_pos,
`endif
  output logic                         busy
);

  localparam int PAY_W   = HAM_DATA_W * NUM_COLS;
  localparam int FRAME_W = HAM_CODE_W * NUM_COLS;
  localparam int COL_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  state_t                  state;
  state_t                  state_next;
  logic [PAY_W-1:0]        payload;
  logic [FRAME_W-1:0]      frame;
  logic [FRAME_W-1:0]      frame_next;
  logic [COL_W-1:0]        col;
  logic                    last_col;
  logic [HAM_DATA_W-1:0]   col_data;
  logic [HAM_CODE_W-1:0]   col_code;

`ifdef HAMMING_ERR_INJECT_EN
  localparam int INJ_W = $clog2(FRAME_W);
  logic             inj_en_q;
  logic [INJ_W-1:0] inj_pos_q;
`endif

  assign last_col = (col == COL_W'(NUM_COLS - 1));
  assign col_data = payload[int'(col)*HAM_DATA_W +: HAM_DATA_W];

  hamming1511_encoder u_col_enc (
    .data (col_data),
    .code (col_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = ENCODE;
      ENCODE:  if (last_col)  state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      ENCODE:  busy = 1'b1;
      HOLD: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    frame_next = frame;
    frame_next[int'(col)*HAM_CODE_W +: HAM_CODE_W] = col_code;
`ifdef HAMMING_ERR_INJECT_EN
    // Flip lands on the same edge that enters HOLD, so the frame never shows it early.
    if (last_col && inj_en_q && (int'(inj_pos_q) < FRAME_W)) begin
      frame_next[inj_pos_q] = ~frame_next[inj_pos_q];
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      payload <= '0;
      frame   <= '0;
      col     <= '0;
`ifdef HAMMING_ERR_INJECT_EN
      inj_en_q  <= 1'b0;
      inj_pos_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            payload <= data_in;
            frame   <= '0;
            col     <= '0;
`ifdef HAMMING_ERR_INJECT_EN
            inj_en_q  <= inj_en;
            inj_pos_q <= inj_pos;
`endif
          end
        end
        ENCODE: begin
          frame <= frame_next;
          if (!last_col) col <= col + COL_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign encoded_out = frame;

endmodule

// File: tb/tb_hamming_2d_encoder.sv
// Directed self-checking bench for hamming_2d_encoder (NUM_COLS=4).
// Injection vectors run only when HAMMING_ERR_INJECT_EN is defined.
module tb_hamming_2d_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [43:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [59:0] encoded_out;
  logic        busy;
`ifdef HAMMING_ERR_INJECT_EN
  logic        inj_en;
  logic [5:0]  inj_pos;
`endif

  int vectors = 0;
  int miscompares = 0;

  hamming_2d_encoder #(.NUM_COLS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_in     (data_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .encoded_out (encoded_out),
`ifdef HAMMING_ERR_INJECT_EN
    .inj_en      (inj_en),
    .inj_pos     (inj_pos),
`endif
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [59:0] observed, input logic [59:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  // Accept a payload, walk the ENCODE cycles, and check the frame once in HOLD.
  task automatic run_block(input string tag, input logic [43:0] pl, input logic [59:0] exp);
    data_in  = pl;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    data_in  = ~pl;
    check({tag, " in_ready encode"}, {59'd0, in_ready}, 60'd0);
    check({tag, " busy encode"}, {59'd0, busy}, 60'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check({tag, " out_valid early"}, {59'd0, out_valid}, 60'd0);
    end
    tick();
    check({tag, " out_valid hold"}, {59'd0, out_valid}, 60'd1);
    check({tag, " in_ready hold"}, {59'd0, in_ready}, 60'd0);
    check({tag, " frame"}, encoded_out, exp);
  endtask

  task automatic release_frame(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " out_valid after release"}, {59'd0, out_valid}, 60'd0);
    check({tag, " in_ready after release"}, {59'd0, in_ready}, 60'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
`ifdef HAMMING_ERR_INJECT_EN
    inj_en    = 1'b0;
    inj_pos   = '0;
`endif
    #12;
    check("reset in_ready", {59'd0, in_ready}, 60'd1);
    check("reset out_valid", {59'd0, out_valid}, 60'd0);
    check("reset busy", {59'd0, busy}, 60'd0);
    check("reset frame", encoded_out, 60'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    run_block("zero", 44'h0, 60'h0);
    release_frame("zero");

    run_block("col0 d0", 44'h001, 60'h0007);
    release_frame("col0 d0");

    run_block("all d10", {4{11'h400}}, {4{15'h408B}});
    release_frame("all d10");

    // Long HOLD with in_valid pulsing: frame must stay put.
    run_block("hold", {11'h0, 11'h0, 11'h001, 11'h0}, 60'h38000);
    data_in = {11'h7FF, 11'h000, 11'h001, 11'h400};
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      tick();
      check("hold out_valid", {59'd0, out_valid}, 60'd1);
      check("hold frame", encoded_out, 60'h38000);
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold release in_ready", {59'd0, in_ready}, 60'd1);
    tick();
    in_valid = 1'b0;
    check("next block busy", {59'd0, busy}, 60'd1);
    for (int i = 0; i < 4; i++) tick();
    check("next block out_valid", {59'd0, out_valid}, 60'd1);
    check("next block frame", encoded_out, {15'h7FFF, 15'h0000, 15'h0007, 15'h408B});
    release_frame("next block");

    // Reset during the second ENCODE cycle.
    data_in  = {4{11'h7FF}};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("abort out_valid", {59'd0, out_valid}, 60'd0);
    check("abort frame", encoded_out, 60'd0);
    check("abort in_ready", {59'd0, in_ready}, 60'd1);
    check("abort busy", {59'd0, busy}, 60'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    run_block("after abort", 44'h001, 60'h0007);
    release_frame("after abort");

`ifdef HAMMING_ERR_INJECT_EN
    inj_en  = 1'b1;
    inj_pos = 6'd17;
    run_block("inject 17", 44'h0, 60'h20000);
    release_frame("inject 17");
    inj_pos = 6'd60;
    run_block("inject out of range", 44'h0, 60'h0);
    release_frame("inject out of range");
    inj_en  = 1'b0;
    inj_pos = 6'd0;
    run_block("inject disarmed", 44'h001, 60'h0007);
    release_frame("inject disarmed");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
